// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl
// Three-phase sequencer: steps through PH0 -> PH1 -> PH2, holding each phase
// for (dwell + 1) cycles, either once (mode=0) or repeatedly (mode=1).
// mode, dwell (and dir) are captured when a start is accepted in IDLE, so
// changing them mid-sequence has no effect.
//
// Optional feature: define PHASE_SEQ_REVERSE_EN to add the dir input.
// dir=1 runs PH0 -> PH2 -> PH1, and a single pass ends after PH1.
//
// Ports:
//   clk    in   rising-edge clock
//   clr    in   synchronous active-high reset
//   start  in   begin a sequence (honoured only in IDLE, and only when stop=0)
//   stop   in   abort a running sequence
//   mode   in   0 = single pass, 1 = continuous
//   dwell  in   cycles per phase minus one (CNT_W bits)
//   dir    in   reverse order (only with PHASE_SEQ_REVERSE_EN)
//   Q0..Q2 out  one-hot phase indicators (registered)
//   busy   out  high in any phase state (registered)
//   done   out  one-cycle pulse on sequence end or abort (registered)
module phase_seq_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] dwell,
`ifdef PHASE_SEQ_REVERSE_EN
  input  logic             dir,
`endif
  output logic             Q0,
  output logic             Q1,
  output logic             Q2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    PH2  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [CNT_W-1:0] r_dwell;
  logic             r_q0;
  logic             r_q1;
  logic             r_q2;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_mode_nxt;
  logic [CNT_W-1:0] w_dwell_nxt;
  logic             w_done_nxt;
  logic             w_last;
  logic             w_dir;

`ifdef PHASE_SEQ_REVERSE_EN
  logic             r_dir;
  logic             w_dir_nxt;
  assign w_dir = r_dir;
`else
  assign w_dir = 1'b0;
`endif

  // Final cycle of the current phase
  assign w_last = (r_cnt == r_dwell);

  // Next-state, counter and latch logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_dwell_nxt = r_dwell;
    w_done_nxt  = 1'b0;
`ifdef PHASE_SEQ_REVERSE_EN
    w_dir_nxt   = r_dir;
`endif
    if (r_state == IDLE) begin
      // start together with stop is not an accepted start
      if (start && !stop) begin
        w_state_nxt = PH0;
        w_cnt_nxt   = '0;
        w_mode_nxt  = mode;
        w_dwell_nxt = dwell;
`ifdef PHASE_SEQ_REVERSE_EN
        w_dir_nxt   = dir;
`endif
      end
    end else if (stop) begin
      // Abort wins over any phase advance
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b1;
    end else if (w_last) begin
      w_cnt_nxt = '0;
      case (r_state)
        PH0: w_state_nxt = w_dir ? PH2 : PH1;
        PH1: begin
          if (!w_dir) begin
            w_state_nxt = PH2;
          end else if (r_mode) begin
            w_state_nxt = PH0;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          if (w_dir) begin
            w_state_nxt = PH1;
          end else if (r_mode) begin
            w_state_nxt = PH0;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      endcase
    end else begin
      // Counter stops at r_dwell, so all-ones dwell never wraps
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_dwell <= '0;
      r_q0    <= 1'b0;
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_dwell <= w_dwell_nxt;
      r_q0    <= (w_state_nxt == PH0);
      r_q1    <= (w_state_nxt == PH1);
      r_q2    <= (w_state_nxt == PH2);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

`ifdef PHASE_SEQ_REVERSE_EN
  // Latched direction
  always_ff @(posedge clk) begin
    if (clr) begin
      r_dir <= 1'b0;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end
`endif

  assign Q0   = r_q0;
  assign Q1   = r_q1;
  assign Q2   = r_q2;
  assign busy = r_busy;
  assign done = r_done;

endmodule
